lpc_host_master: RTL and testbench

- LPC host cycle engine inside top; issues single-byte TPM-locality I/O reads and writes on the 4-bit LAD bus toward the TPM header (ja[3:0]).
- Upstream: the UART command decoder supplies one request at a time through a valid/ready handshake. Downstream: the TPM device, or the bench's LPC peripheral model.
- Returns read data or an error status on a one-cycle response strobe.
- The top-level IOBUF wrapper lives outside this block. It connects IOBUF T = ~lad_oe.

---
 rtl/lpc_host_master.sv | 200 ++++++++++++++++++++
 tb/tb_lpc_host_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host_master.sv
// LPC host cycle engine: single-byte I/O read/write on the 4-bit LAD bus,
// one request in through valid/ready, one-clk response strobe out.
module lpc_host_master #(
  parameter int CLK_DIV      = 1,
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic [3:0]  lad_in,
  output logic        lframe_n,
  output logic [4:0]  dbg_state_o
);

  // Handshake: a request transfers on any clk where req_valid && req_ready;
  // req_* are don't-care otherwise. req_ready is high in IDLE and during the
  // one-clk response states, so a new cycle can start right behind a response.

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_CTDIR, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_WDATA0, S_WDATA1, S_HTAR0, S_HTAR1, S_SYNC, S_RDATA0, S_RDATA1,
    S_PTAR0, S_PTAR1, S_DONE, S_ABORT, S_ERESP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] TIMEOUT  = 8'(SYNC_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  div_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        tick;
  logic        accept;

  assign tick        = (div_q == DIV_LAST);
  assign req_ready   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERESP);
  assign accept      = req_valid && req_ready;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    lad_out   = 4'hF;
    lad_oe    = 1'b0;
    lframe_n  = 1'b1;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        lad_oe   = 1'b1;
        lad_out  = 4'b0101;
        lframe_n = 1'b0;
        if (tick) state_d = S_CTDIR;
      end
      S_CTDIR: begin
        lad_oe  = 1'b1;
        lad_out = wr_q ? 4'b0010 : 4'b0000;
        if (tick) state_d = S_ADDR0;
      end
      S_ADDR0: begin
        lad_oe  = 1'b1;
        lad_out = addr_q[15:12];
        if (tick) state_d = S_ADDR1;
      end
      S_ADDR1: begin
        lad_oe  = 1'b1;
        lad_out = addr_q[11:8];
        if (tick) state_d = S_ADDR2;
      end
      S_ADDR2: begin
        lad_oe  = 1'b1;
        lad_out = addr_q[7:4];
        if (tick) state_d = S_ADDR3;
      end
      S_ADDR3: begin
        lad_oe  = 1'b1;
        lad_out = addr_q[3:0];
        if (tick) state_d = wr_q ? S_WDATA0 : S_HTAR0;
      end
      S_WDATA0: begin
        lad_oe  = 1'b1;
        lad_out = wdata_q[3:0];
        if (tick) state_d = S_WDATA1;
      end
      S_WDATA1: begin
        lad_oe  = 1'b1;
        lad_out = wdata_q[7:4];
        if (tick) state_d = S_HTAR0;
      end
      S_HTAR0: begin
        lad_oe  = 1'b1;
        lad_out = 4'hF;
        if (tick) state_d = S_HTAR1;
      end
      S_HTAR1: begin
        if (tick) begin
          state_d = S_SYNC;
          cnt_d   = 8'd1;
        end
      end
      S_SYNC: begin
        // A ready nibble wins even on the tick the wait budget runs out.
        if (tick) begin
          if (lad_in == 4'b0000) begin
            state_d = wr_q ? S_PTAR0 : S_RDATA0;
          end else if (cnt_q >= TIMEOUT) begin
            state_d = S_ABORT;
            cnt_d   = 8'd0;
          end else if (lad_in == 4'b0101 || lad_in == 4'b0110) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            state_d = S_ABORT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_RDATA0: begin
        if (tick) begin
          rdata_d[3:0] = lad_in;
          state_d      = S_RDATA1;
        end
      end
      S_RDATA1: begin
        if (tick) begin
          rdata_d[7:4] = lad_in;
          state_d      = S_PTAR0;
        end
      end
      S_PTAR0: begin
        if (tick) state_d = S_PTAR1;
      end
      S_PTAR1: begin
        if (tick) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        state_d   = accept ? S_START : S_IDLE;
      end
      S_ABORT: begin
        lad_oe   = 1'b1;
        lad_out  = 4'hF;
        lframe_n = 1'b0;
        if (tick) begin
          if (cnt_q == 8'd3) state_d = S_ERESP;
          else               cnt_d   = cnt_q + 8'd1;
        end
      end
      S_ERESP: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = accept ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The divider restarts on accept so START always spans a full tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= (accept || tick) ? 8'd0 : div_q + 8'd1;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 8'h00;
      end else begin
        rdata_q <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_lpc_host_master.sv
// Bench for lpc_host_master: LPC peripheral model, request driver and a
// response scoreboard, run against a CLK_DIV=1 and a CLK_DIV=4 instance.
module tb_lpc_host_master;

  localparam int W = 17;  // {err, rdata[7:0], latency_ticks[7:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  int          cur_div;
  logic        req_valid, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [3:0]  lad_in;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_lad_oe, a_lframe_n;
  logic [7:0]  a_rsp_rdata;
  logic [3:0]  a_lad_out;
  logic [4:0]  a_dbg;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_lad_oe, b_lframe_n;
  logic [7:0]  b_rsp_rdata;
  logic [3:0]  b_lad_out;
  logic [4:0]  b_dbg;

  logic        m_req_ready, m_rsp_valid, m_rsp_err, m_lad_oe, m_lframe_n;
  logic [7:0]  m_rsp_rdata;
  logic [3:0]  m_lad_out;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  lpc_host_master #(.CLK_DIV(1), .SYNC_TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .lad_out(a_lad_out), .lad_oe(a_lad_oe), .lad_in(lad_in),
    .lframe_n(a_lframe_n), .dbg_state_o(a_dbg)
  );

  lpc_host_master #(.CLK_DIV(4), .SYNC_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .lad_out(b_lad_out), .lad_oe(b_lad_oe), .lad_in(lad_in),
    .lframe_n(b_lframe_n), .dbg_state_o(b_dbg)
  );

  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign m_lad_out   = sel ? b_lad_out   : a_lad_out;
  assign m_lad_oe    = sel ? b_lad_oe    : a_lad_oe;
  assign m_lframe_n  = sel ? b_lframe_n  : a_lframe_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0, start_cyc = 0, rsp_cyc = 0, last_gap = 0;
  logic prev_start = 1'b0, prev_rsp = 1'b0, start_now;
  logic [W-1:0] got_rsp, exp_rsp;
  logic [7:0] lat;

  always @(negedge clk) begin
    cyc++;
    start_now = m_lad_oe && !m_lframe_n && (m_lad_out == 4'b0101);
    if (start_now && !prev_start) begin
      start_cyc = cyc;
      last_gap  = cyc - rsp_cyc;
    end
    prev_start = start_now;
    if (m_rsp_valid) begin
      check_eq("rsp_one_clk", 32'(prev_rsp), 32'd0);
      rsp_cyc = cyc;
      check_eq("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_rsp = exp_q.pop_front();
        lat     = 8'((cyc - start_cyc) / cur_div);
        got_rsp = {m_rsp_err, m_rsp_rdata, lat};
        check_eq("rsp_err_data_lat", 32'(got_rsp), 32'(exp_rsp));
      end
    end
    prev_rsp = m_rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req(input logic wr, input logic [15:0] addr, input logic [7:0] wdata);
    logic done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int t = 0; t < 400 && !done; t++) begin
      if (m_req_ready) done = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("req_accepted", 32'(done), 32'd1);
  endtask

  // Peripheral model: checks host nibbles, then plays SYNC/data on lad_in.
  task automatic lpc_model(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int nwait, input logic [3:0] wait_nib,
                           input logic drive_final, input logic [3:0] final_nib,
                           input logic exp_abort);
    logic [3:0] hn[9];
    int n;
    logic found;
    found = 1'b0;
    n = wr ? 9 : 7;
    hn[0] = 4'b0101;
    hn[1] = wr ? 4'b0010 : 4'b0000;
    hn[2] = addr[15:12];
    hn[3] = addr[11:8];
    hn[4] = addr[7:4];
    hn[5] = addr[3:0];
    hn[6] = wr ? wdata[3:0] : 4'hF;
    hn[7] = wdata[7:4];
    hn[8] = 4'hF;
    for (int t = 0; t < 400 && !found; t++) begin
      if (m_lad_oe && !m_lframe_n && m_lad_out == 4'b0101) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("start_seen", 32'(found), 32'd1);
    if (!found) return;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("lframe_n_nib%0d", i), 32'(m_lframe_n), (i == 0) ? 32'd0 : 32'd1);
      check_eq($sformatf("lad_oe_nib%0d", i), 32'(m_lad_oe), 32'd1);
      for (int c = 0; c < cur_div; c++) begin
        check_eq($sformatf("lad_nib%0d", i), 32'(m_lad_out), 32'(hn[i]));
        @(negedge clk);
      end
    end
    check_eq("htar1_release", 32'(m_lad_oe), 32'd0);
    adv(cur_div);
    for (int w = 0; w < nwait; w++) begin
      lad_in = wait_nib;
      adv(cur_div);
    end
    if (drive_final) begin
      lad_in = final_nib;
      adv(cur_div);
    end
    lad_in = 4'hF;
    if (exp_abort) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("abort_lframe_n", 32'(m_lframe_n), 32'd0);
        check_eq("abort_oe", 32'(m_lad_oe), 32'd1);
        check_eq("abort_lad", 32'(m_lad_out), 32'hF);
        adv(cur_div);
      end
    end else if (!wr) begin
      check_eq("rdata_phase_oe", 32'(m_lad_oe), 32'd0);
      lad_in = rdata[3:0];
      adv(cur_div);
      lad_in = rdata[7:4];
      adv(cur_div);
      lad_in = 4'hF;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
    adv(2);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] exp_of(input logic wr, input logic [7:0] rdata, input int nwait,
                                          input logic drive_final, input logic exp_abort);
    int ticks;
    if (exp_abort) begin
      ticks = 8 + (wr ? 2 : 0) + nwait + (drive_final ? 1 : 0) + 4;
      return {1'b1, 8'h00, 8'(ticks)};
    end
    return {1'b0, wr ? 8'h00 : rdata, 8'(13 + nwait)};
  endfunction

  task automatic run_cycle(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int nwait, input logic [3:0] wait_nib,
                           input logic drive_final, input logic [3:0] final_nib,
                           input logic exp_abort);
    exp_q.push_back(exp_of(wr, rdata, nwait, drive_final, exp_abort));
    fork
      send_req(wr, addr, wdata);
      lpc_model(wr, addr, wdata, rdata, nwait, wait_nib, drive_final, final_nib, exp_abort);
    join
    wait_drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adv(3);
    rst = 1'b0;
    adv(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; cur_div = 1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
    lad_in = 4'hF;
    do_reset();

    check_eq("rst_req_ready", 32'(m_req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(m_rsp_rdata), 32'd0);
    check_eq("rst_rsp_err", 32'(m_rsp_err), 32'd0);
    check_eq("rst_lad_out", 32'(m_lad_out), 32'hF);
    check_eq("rst_lad_oe", 32'(m_lad_oe), 32'd0);
    check_eq("rst_lframe_n", 32'(m_lframe_n), 32'd1);

    run_cycle(1'b0, 16'h0018, 8'h00, 8'h94, 0, 4'h0, 1'b1, 4'h0, 1'b0);
    run_cycle(1'b1, 16'h0000, 8'h02, 8'h00, 0, 4'h0, 1'b1, 4'h0, 1'b0);
    run_cycle(1'b0, 16'h004E, 8'h00, 8'hC4, 3, 4'b0110, 1'b1, 4'h0, 1'b0);
    run_cycle(1'b0, 16'h0020, 8'h00, 8'h00, 16, 4'b0101, 1'b0, 4'h0, 1'b1);
    run_cycle(1'b0, 16'h0024, 8'h00, 8'h00, 0, 4'h0, 1'b1, 4'b1010, 1'b1);
    // Ready on the last allowed SYNC tick still completes.
    run_cycle(1'b1, 16'h0F0A, 8'h5A, 8'h00, 15, 4'b0101, 1'b1, 4'h0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wd, rd;
      int          nw;
      wr   = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 65535));
      wd   = 8'($urandom_range(0, 255));
      rd   = 8'($urandom_range(0, 255));
      nw   = $urandom_range(0, 3);
      run_cycle(wr, addr, wd, rd, nw, ($urandom_range(0, 1) != 0) ? 4'b0101 : 4'b0110,
                1'b1, 4'h0, 1'b0);
    end

    // Reset during ADDR2: no response may follow.
    send_req(1'b0, 16'h1234, 8'h00);
    adv(4);
    check_eq("pre_rst_lad_addr2", 32'(m_lad_out), 32'h3);
    check_eq("pre_rst_req_ready", 32'(m_req_ready), 32'd0);
    rst = 1'b1;
    adv(1);
    check_eq("midrst_lad_oe", 32'(m_lad_oe), 32'd0);
    check_eq("midrst_lframe_n", 32'(m_lframe_n), 32'd1);
    check_eq("midrst_req_ready", 32'(m_req_ready), 32'd1);
    rst = 1'b0;
    adv(30);
    run_cycle(1'b0, 16'h00AB, 8'h00, 8'h3C, 1, 4'b0110, 1'b1, 4'h0, 1'b0);

    // CLK_DIV=4 instance: back-to-back reads with req_valid held.
    sel = 1'b1;
    cur_div = 4;
    do_reset();
    exp_q.push_back(exp_of(1'b0, 8'hA5, 0, 1'b1, 1'b0));
    exp_q.push_back(exp_of(1'b0, 8'h7E, 2, 1'b1, 1'b0));
    fork
      begin
        send_req(1'b0, 16'h0080, 8'h00);
        send_req(1'b0, 16'h0081, 8'h00);
      end
      begin
        lpc_model(1'b0, 16'h0080, 8'h00, 8'hA5, 0, 4'h0, 1'b1, 4'h0, 1'b0);
        lpc_model(1'b0, 16'h0081, 8'h00, 8'h7E, 2, 4'b0101, 1'b1, 4'h0, 1'b0);
      end
    join
    wait_drain();
    check_eq("b2b_gap_within_tick", 32'(last_gap >= 1 && last_gap <= cur_div), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
